// File: rtl/imuldiv_pkg.sv
// Shared encodings for the iterative divider's issue side: pipeline op codes,
// divider request sign select, and the issue-unit FSM state encoding.
package imuldiv_pkg;

   localparam logic [1:0] FN_DIV  = 2'b00;
   localparam logic [1:0] FN_DIVU = 2'b01;
   localparam logic [1:0] FN_REM  = 2'b10;
   localparam logic [1:0] FN_REMU = 2'b11;

   localparam logic DIVREQ_SIGNED   = 1'b1;
   localparam logic DIVREQ_UNSIGNED = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } state_t;

endpackage

// File: rtl/imuldiv_wait_timer.sv
// Saturating 8-bit wait counter with a sticky expiry flag; the flag survives
// clr and is only cleared by reset.
module imuldiv_wait_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] count;
   logic [7:0] count_next;

   assign count_next = (count == 8'hFF) ? count : count + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         expired <= 1'b0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count_next;
         if (count_next == LIMIT) expired <= 1'b1;
      end
   end

endmodule

// File: rtl/imuldiv_div_issue_unit.sv
// Issues one div/divu/rem/remu op to the iterative divider, selects quotient or
// remainder from the response and hands the tagged result to writeback.
module imuldiv_div_issue_unit
   import imuldiv_pkg::*;
#(
   parameter int TAG_W          = 5,
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit BYPASS_DIVZERO = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_val,
   output logic              op_rdy,
   input  logic [1:0]        op_fn,
   input  logic [31:0]       op_a,
   input  logic [31:0]       op_b,
   input  logic [TAG_W-1:0]  op_tag,
   output logic              divreq_val,
   input  logic              divreq_rdy,
   output logic              divreq_msg_fn,
   output logic [31:0]       divreq_msg_a,
   output logic [31:0]       divreq_msg_b,
   input  logic              divresp_val,
   output logic              divresp_rdy,
   input  logic [63:0]       divresp_msg_result,
   output logic              wb_val,
   input  logic              wb_rdy,
   output logic [31:0]       wb_data,
   output logic [TAG_W-1:0]  wb_tag,
   output logic              busy,
   output logic              err_timeout,
   output state_t            dbg_state
);

   // Handshakes: a transfer happens on a rising edge where val && rdy are both
   // high; a producer holding val keeps its message stable until that edge,
   // and val never depends combinationally on rdy (all outputs are flops).

   state_t state;
   logic   rem_sel;

   assign dbg_state = state;

   imuldiv_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (state == ST_REQ && divreq_rdy),
      .en     (state == ST_WAIT),
      .expired(err_timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         rem_sel       <= 1'b0;
         op_rdy        <= 1'b1;
         divreq_val    <= 1'b0;
         divreq_msg_fn <= 1'b0;
         divreq_msg_a  <= '0;
         divreq_msg_b  <= '0;
         divresp_rdy   <= 1'b0;
         wb_val        <= 1'b0;
         wb_data       <= '0;
         wb_tag        <= '0;
         busy          <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (op_val) begin
                  rem_sel       <= op_fn[1];
                  wb_tag        <= op_tag;
                  divreq_msg_fn <= op_fn[0] ? DIVREQ_UNSIGNED : DIVREQ_SIGNED;
                  divreq_msg_a  <= op_a;
                  divreq_msg_b  <= op_b;
                  op_rdy        <= 1'b0;
                  busy          <= 1'b1;
                  if (BYPASS_DIVZERO && op_b == '0) begin
                     // x/0 = all ones, x%0 = x, for both signednesses
                     wb_data <= op_fn[1] ? op_a : 32'hFFFF_FFFF;
                     wb_val  <= 1'b1;
                     state   <= ST_WB;
                  end else begin
                     divreq_val <= 1'b1;
                     state      <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (divreq_rdy) begin
                  divreq_val  <= 1'b0;
                  divresp_rdy <= 1'b1;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (divresp_val) begin
                  wb_data     <= rem_sel ? divresp_msg_result[63:32]
                                         : divresp_msg_result[31:0];
                  divresp_rdy <= 1'b0;
                  wb_val      <= 1'b1;
                  state       <= ST_WB;
               end
            end
            ST_WB: begin
               if (wb_rdy) begin
                  wb_val <= 1'b0;
                  op_rdy <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
